uart_tx_fifo: RTL



---
 rtl/uart_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 90 +++++++++
 rtl/uart_tx_fifo.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART transmit path.
//   tx_state_t    : transmitter FSM states (PARITY is only reached when the
//                   UART_TX_PARITY_EN build option is defined).
//   DEFAULT_*     : board clock and line-rate defaults.
//   clks_per_bit  : clock cycles per serial bit, truncating division.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int DEFAULT_CLK_FREQ_HZ = 23_000_000;
  localparam int DEFAULT_BAUD        = 115_200;

  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a registered head-of-queue output.
//   clk, rst  : clock and synchronous active-high reset (pointers, count,
//               overflow; the storage array itself is not reset).
//   wr_en     : push request; accepted only when full=0 at the same edge.
//   wr_data   : byte to push.
//   rd_en     : pop request; ignored when empty.
//   rd_data   : current head entry, valid whenever empty=0.
//   full      : DEPTH entries held.  empty : no entries held.
//   count     : occupancy, 0..DEPTH.
//   overflow  : sticky, set by a push attempted while full.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    rd_ptr_next;
  logic [AW:0]      count_reg;
  logic [WIDTH-1:0] head_reg;
  logic             overflow_reg;
  logic             push;
  logic             pop;

  assign full        = (count_reg == DEPTH_CNT);
  assign empty       = (count_reg == '0);
  // full is judged on the pre-edge occupancy, so a push while full is
  // dropped even if a pop frees a slot on the same edge.
  assign push        = wr_en && !full;
  assign pop         = rd_en && !empty;
  assign rd_ptr_next = pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;

  // Storage plus registered head. The head register always tracks the
  // entry the read pointer will point at after this edge; when that entry
  // is the one being written right now (FIFO empty, or about to become
  // empty), the incoming byte is forwarded instead of the stale array word.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
    if (push && (wr_ptr_reg == rd_ptr_next)) begin
      head_reg <= wr_data;
    end else begin
      head_reg <= mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      rd_ptr_reg <= rd_ptr_next;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
      if (wr_en && full) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign rd_data  = head_reg;
  assign count    = count_reg;
  assign overflow = overflow_reg;

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: memory-mapped UART transmitter with a byte FIFO.
//   clk       : CPU clock, all logic on its rising edge.
//   rst       : synchronous active-high reset; aborts any frame in flight
//               and discards queued bytes.
//   wr_en     : push request from the IO decode, one byte per cycle.
//   wr_data   : byte to push.
//   full      : FIFO holds FIFO_DEPTH entries.
//   empty     : FIFO holds no entries.
//   count     : FIFO occupancy.
//   busy      : a frame is on the line.
//   overflow  : sticky, set by a push while full; cleared only by rst.
//   tx        : serial line, idle high, frames 8N1 LSB first.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (8E1 frames).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ,
  parameter int BAUD        = DEFAULT_BAUD,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [7:0]                  wr_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        busy,
  output logic                        overflow,
  output logic                        tx
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_fifo: CLK_FREQ_HZ / BAUD must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
  end

  tx_state_t        state_reg, state_next;
  logic [CNT_W-1:0] baud_cnt_reg, baud_cnt_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic             tx_reg, tx_next;
  logic             busy_reg, busy_next;
  logic             pop;
  logic             bit_done;
  logic [7:0]       fifo_rd_data;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (fifo_rd_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  assign bit_done = (baud_cnt_reg == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg + CNT_W'(1);
    bit_idx_next  = bit_idx_reg;
    shift_next    = shift_reg;
    pop           = 1'b0;

    // Every transition clears the baud counter so each bit period is
    // measured from its own state entry and no error accumulates.
    case (state_reg)
      IDLE: begin
        baud_cnt_next = '0;
        if (!empty) begin
          pop        = 1'b1;
          shift_next = fifo_rd_data;
          state_next = START;
        end
      end
      START: begin
        if (bit_done) begin
          baud_cnt_next = '0;
          bit_idx_next  = '0;
          state_next    = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_cnt_next = '0;
          if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          baud_cnt_next = '0;
          state_next    = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          baud_cnt_next = '0;
          // Chain straight into the next start bit when more data waits.
          if (!empty) begin
            pop        = 1'b1;
            shift_next = fifo_rd_data;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        baud_cnt_next = '0;
        state_next    = IDLE;
      end
    endcase

    // tx and busy are registered from the next state so the pin never
    // glitches on decode of the state vector.
    busy_next = (state_next != IDLE);
    tx_next   = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[bit_idx_next];
      PARITY:  tx_next = ^shift_next;
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
      tx_reg       <= tx_next;
      busy_reg     <= busy_next;
    end
  end

  assign tx   = tx_reg;
  assign busy = busy_reg;

endmodule
